// File: rtl/sipo_stream.sv
// sipo_stream
// Parametrised serial-in/parallel-out deserialiser. Serial bits are sampled on
// an internal clock-enable tick (prescaled from clk by DIV), collected into a
// WIDTH-bit word and handed to the consumer on a registered valid/ready port.
// A word completed before the previous one was accepted overwrites it and sets
// the sticky overrun flag.
//
// Optional feature macro: SIPO_PARITY_EN
//    When defined, each frame carries one trailing even-parity bit after the
//    data bits. The parity bit is not stored in po; parity_err reports the
//    check result for the word currently in po.
//
// Parameters:
//    WIDTH      word width in bits (2..32)
//    DIV        sample tick every DIV enabled clocks (1 = every cycle)
//    MSB_FIRST  0: first bit lands in po[0]; 1: first bit lands in po[WIDTH-1]
//
// Ports:
//    clk         system clock, all state on rising edge
//    clr_n       asynchronous active-low reset
//    en          sampling enable (also gates the prescaler)
//    si          serial data, sampled on tick
//    po          last completed word
//    po_valid    po holds an unconsumed word
//    po_ready    consumer accepts po when po_valid && po_ready
//    busy        partial word in progress
//    overrun     sticky, a word was overwritten before acceptance
//    parity_err  (SIPO_PARITY_EN only) parity result for current po

module sipo_stream #(
   parameter int WIDTH     = 8,
   parameter int DIV       = 1,
   parameter int MSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic             si,
   output logic [WIDTH-1:0] po,
   output logic             po_valid,
   input  logic             po_ready,
   output logic             busy,
   output logic             overrun
`ifdef SIPO_PARITY_EN
   ,
   output logic             parity_err
`endif
);

`ifdef SIPO_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW = $clog2(FRAME);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    div_cnt_q, div_cnt_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] po_q, po_d;
   logic             po_valid_q, po_valid_d;
   logic             overrun_q, overrun_d;
   logic             tick;
   logic             dataTick;
   logic             lastTick;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] word;
`ifdef SIPO_PARITY_EN
   logic             parity_q, parity_d;
`endif

   // Prescaler and shift datapath. Dropping en restarts the prescaler phase
   // but leaves the partial frame (bit_cnt, sh) untouched.
   always_comb begin
      tick      = en && (div_cnt_q == DIV_LAST);
      div_cnt_d = div_cnt_q + DW'(1);
      if (!en || tick) begin
         div_cnt_d = '0;
      end

      lastTick = tick && (bit_cnt_q == CNT_LAST);
`ifdef SIPO_PARITY_EN
      // The parity tick samples si for the check only; sh keeps the data bits.
      dataTick = tick && (bit_cnt_q != CW'(WIDTH));
`else
      dataTick = tick;
`endif

      if (MSB_FIRST != 0) begin
         shifted = {sh_q[WIDTH-2:0], si};
      end else begin
         shifted = {si, sh_q[WIDTH-1:1]};
      end
      sh_d = dataTick ? shifted : sh_q;

      bit_cnt_d = bit_cnt_q;
      if (tick) begin
         bit_cnt_d = lastTick ? '0 : bit_cnt_q + CW'(1);
      end

`ifdef SIPO_PARITY_EN
      word     = sh_q;
      parity_d = lastTick ? ((^sh_q) ^ si) : parity_q;
`else
      // Completion happens on the final data tick, so include that bit now.
      word = shifted;
`endif
   end

   // Output handshake: a completing word always wins (newest data), and
   // overrun is only raised when the old word was not taken on this edge.
   always_comb begin
      po_d       = lastTick ? word : po_q;
      po_valid_d = lastTick | (po_valid_q & ~po_ready);
      overrun_d  = overrun_q | (lastTick & po_valid_q & ~po_ready);
   end

   // Frame state: IDLE means no bits collected yet.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tick)     state_d = SHIFT;
         SHIFT:   if (lastTick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q    <= IDLE;
         div_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         sh_q       <= '0;
         po_q       <= '0;
         po_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
`ifdef SIPO_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         sh_q       <= sh_d;
         po_q       <= po_d;
         po_valid_q <= po_valid_d;
         overrun_q  <= overrun_d;
`ifdef SIPO_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign po       = po_q;
   assign po_valid = po_valid_q;
   assign overrun  = overrun_q;
   assign busy     = (state_q == SHIFT);
`ifdef SIPO_PARITY_EN
   assign parity_err = parity_q;
`endif

endmodule

// File: tb/tb_sipo_stream.sv
// tb_sipo_stream
// Scoreboard bench for sipo_stream. Three instances share clk and reset:
//    dutL  WIDTH=8 DIV=1 LSB-first
//    dutM  WIDTH=8 DIV=1 MSB-first (same serial inputs as dutL)
//    dutD  WIDTH=8 DIV=4 LSB-first (own inputs)
// Stimulus pushes the expected accepted word into a per-instance queue; a
// monitor per instance pops and compares whenever a word is accepted.

module tb_sipo_stream;

   typedef struct packed {
      logic [7:0] word;
      logic       ovr;
   } expect_t;

   logic       clk;
   logic       clrN;
   logic       en, si, ready;
   logic       enD, siD, readyD;
   logic [7:0] poL, poM, poD;
   logic       validL, validM, validD;
   logic       busyL, busyM, busyD;
   logic       ovrL, ovrM, ovrD;
`ifdef SIPO_PARITY_EN
   logic       parL, parM, parD;
`endif

   expect_t qL[$];
   expect_t qM[$];
   expect_t qD[$];

   int checks = 0;
   int errors = 0;

   sipo_stream #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) dutL (
      .clk(clk), .clr_n(clrN), .en(en), .si(si),
      .po(poL), .po_valid(validL), .po_ready(ready),
      .busy(busyL), .overrun(ovrL)
`ifdef SIPO_PARITY_EN
      , .parity_err(parL)
`endif
   );

   sipo_stream #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) dutM (
      .clk(clk), .clr_n(clrN), .en(en), .si(si),
      .po(poM), .po_valid(validM), .po_ready(ready),
      .busy(busyM), .overrun(ovrM)
`ifdef SIPO_PARITY_EN
      , .parity_err(parM)
`endif
   );

   sipo_stream #(.WIDTH(8), .DIV(4), .MSB_FIRST(0)) dutD (
      .clk(clk), .clr_n(clrN), .en(enD), .si(siD),
      .po(poD), .po_valid(validD), .po_ready(readyD),
      .busy(busyD), .overrun(ovrD)
`ifdef SIPO_PARITY_EN
      , .parity_err(parD)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic pushLM(input logic [7:0] seq, input logic ovr);
      expect_t e;
      e.word = seq;
      e.ovr  = ovr;
      qL.push_back(e);
      e.word = rev8(seq);
      qM.push_back(e);
   endtask

   // seq[0] is the first bit on the wire; one bit per clock at DIV=1.
   task automatic applyStimulus(input logic [7:0] seq, input int nBits);
      en = 1'b1;
      for (int i = 0; i < nBits; i++) begin
         si = seq[i];
         @(posedge clk);
         #1;
      end
      en = 1'b0;
   endtask

   // DIV=4 instance: every bit held for 4 clocks; optional en gap after 4 bits.
   task automatic applyStimulusSlow(input logic [7:0] seq, input int gapLen);
      enD = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         siD = seq[(c-1)/4];
         if (c == 32) checkOutput("slow_valid_before_last", 32'(validD), 32'd0);
         @(posedge clk);
         #1;
         if (c == 16 && gapLen > 0) begin
            enD = 1'b0;
            repeat (gapLen) @(posedge clk);
            #1;
            checkOutput("slow_busy_hold", 32'(busyD), 32'd1);
            checkOutput("slow_valid_hold", 32'(validD), 32'd0);
            enD = 1'b1;
         end
      end
      checkOutput("slow_valid_after_last", 32'(validD), 32'd1);
      enD = 1'b0;
   endtask

   always @(negedge clk) begin : monL
      expect_t e;
      if (validL && ready) begin
         if (qL.size() == 0) begin
            checkOutput("monL_unexpected_word", 32'd1, 32'd0);
         end else begin
            e = qL.pop_front();
            checkOutput("monL_po", 32'(poL), 32'(e.word));
            checkOutput("monL_overrun", 32'(ovrL), 32'(e.ovr));
         end
      end
   end

   always @(negedge clk) begin : monM
      expect_t e;
      if (validM && ready) begin
         if (qM.size() == 0) begin
            checkOutput("monM_unexpected_word", 32'd1, 32'd0);
         end else begin
            e = qM.pop_front();
            checkOutput("monM_po", 32'(poM), 32'(e.word));
            checkOutput("monM_overrun", 32'(ovrM), 32'(e.ovr));
         end
      end
   end

   always @(negedge clk) begin : monD
      expect_t e;
      if (validD && readyD) begin
         if (qD.size() == 0) begin
            checkOutput("monD_unexpected_word", 32'd1, 32'd0);
         end else begin
            e = qD.pop_front();
            checkOutput("monD_po", 32'(poD), 32'(e.word));
            checkOutput("monD_overrun", 32'(ovrD), 32'(e.ovr));
         end
      end
   end

   initial begin
      expect_t e;
      clrN   = 1'b0;
      en     = 1'b0;
      si     = 1'b0;
      ready  = 1'b1;
      enD    = 1'b0;
      siD    = 1'b0;
      readyD = 1'b1;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_poL", 32'(poL), 32'd0);
      checkOutput("rst_validL", 32'(validL), 32'd0);
      checkOutput("rst_busyL", 32'(busyL), 32'd0);
      checkOutput("rst_ovrL", 32'(ovrL), 32'd0);
      checkOutput("rst_poM", 32'(poM), 32'd0);
      checkOutput("rst_validM", 32'(validM), 32'd0);
      checkOutput("rst_poD", 32'(poD), 32'd0);
      checkOutput("rst_validD", 32'(validD), 32'd0);
      checkOutput("rst_busyD", 32'(busyD), 32'd0);
      checkOutput("rst_ovrD", 32'(ovrD), 32'd0);
      clrN = 1'b1;
      @(posedge clk);
      #1;

      // Basic word 0,1,1,1,1,0,0,0 -> 0x1E LSB-first, 0x78 MSB-first
      pushLM(8'h1E, 1'b0);
      applyStimulus(8'h1E, 8);
      checkOutput("w1_validL", 32'(validL), 32'd1);
      checkOutput("w1_poM", 32'(poM), 32'h78);
      checkOutput("w1_busyL_done", 32'(busyL), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("w1_validL_one_cycle", 32'(validL), 32'd0);
      checkOutput("w1_validM_one_cycle", 32'(validM), 32'd0);

      // Back-to-back words with ready high: no overrun
      pushLM(8'hA5, 1'b0);
      applyStimulus(8'hA5, 1);
      checkOutput("b2b_busy_midframe", 32'(busyL), 32'd1);
      applyStimulus(8'hA5 >> 1, 7);
      pushLM(8'h3C, 1'b0);
      applyStimulus(8'h3C, 8);
      checkOutput("b2b_no_overrun", 32'(ovrL), 32'd0);
      @(posedge clk);
      #1;

      // Overrun: 0x1E is overwritten by 0x55 while ready is low
      ready = 1'b0;
      applyStimulus(8'h1E, 8);
      pushLM(8'h55, 1'b1);
      applyStimulus(8'h55, 8);
      checkOutput("ovr_poL", 32'(poL), 32'h55);
      checkOutput("ovr_poM", 32'(poM), 32'hAA);
      checkOutput("ovr_validL", 32'(validL), 32'd1);
      checkOutput("ovr_flagL", 32'(ovrL), 32'd1);
      ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("ovr_valid_after_accept", 32'(validL), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("ovr_sticky", 32'(ovrL), 32'd1);

      // Asynchronous reset after 5 of 8 bits (all ones, to expose stale bits)
      applyStimulus(8'hFF, 5);
      checkOutput("rst_mid_busy_before", 32'(busyL), 32'd1);
      #2;
      clrN = 1'b0;
      #1;
      checkOutput("arst_poL", 32'(poL), 32'd0);
      checkOutput("arst_poM", 32'(poM), 32'd0);
      checkOutput("arst_busyL", 32'(busyL), 32'd0);
      checkOutput("arst_ovrL", 32'(ovrL), 32'd0);
      #1;
      clrN = 1'b1;
      @(posedge clk);
      #1;
      pushLM(8'h96, 1'b0);
      applyStimulus(8'h96, 8);
      checkOutput("post_rst_busy", 32'(busyL), 32'd0);
      @(posedge clk);
      #1;

      // DIV=4: plain word, then a word with a 10-cycle en gap mid-frame
      e.word = 8'hC9;
      e.ovr  = 1'b0;
      qD.push_back(e);
      applyStimulusSlow(8'hC9, 0);
      e.word = 8'h35;
      qD.push_back(e);
      applyStimulusSlow(8'h35, 10);
      @(posedge clk);
      #1;

      checkOutput("qL_drained", 32'(qL.size()), 32'd0);
      checkOutput("qM_drained", 32'(qM.size()), 32'd0);
      checkOutput("qD_drained", 32'(qD.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
